// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared helpers for sync_fifo_flex: pointer/count width calculation and the
// parameter legality predicates evaluated at elaboration by the top level.
// No ports (package).
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    // Pointers carry one extra wrap bit above the memory address bits, so a
    // full FIFO (wr_ptr - rd_ptr == depth) is distinguishable from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Natural pointer overflow only wraps correctly for power-of-two depths.
    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && is_pow2(depth);
    endfunction

    function automatic bit af_thresh_ok(input int thresh, input int depth);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

    function automatic bit ae_thresh_ok(input int thresh, input int depth);
        return (thresh >= 0) && (thresh <= depth - 1);
    endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// Simple dual-port storage array for sync_fifo_flex: one write port, one read
// port. REG_READ selects a registered read port (enable-gated, reset to zero)
// or an asynchronous read port (show-ahead use).
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (read register only)
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable (registered read port only)
//   i_raddr  in   read address
//   o_rdata  out  read data
// -----------------------------------------------------------------------------
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter bit REG_READ   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    // NOTE: the array has no reset branch on purpose; resetting it would turn
    // a RAM into a flop bank, and stale contents are never visible because
    // the pointers gate every read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            // NOTE: sequential state is assigned with <= so every flop samples
            // pre-edge values regardless of statement order.
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rdata;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (i_re) begin
                    r_rdata <= r_mem[i_raddr];
                end
            end

            assign o_rdata = r_rdata;
        end else begin : g_async_read
            // Reset and read enable have no meaning for an asynchronous port.
            logic w_unused;
            assign w_unused = rst | i_re;
            assign o_rdata  = r_mem[i_raddr];
        end
    endgenerate

endmodule : sync_fifo_ram

// File: rtl/sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// sync_fifo_flex
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, synchronous flush and sticky overflow/underflow flags.
//
// Compile-time option:
//   SYNC_FIFO_FWFT_EN  defined   -> show-ahead: data_out = mem[rd_ptr]
//                                   combinationally, valid while !empty
//                      undefined -> data_out registered, updated on read
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   cs           in   chip select, gates wr_en/rd_en/flush/clr_err
//   wr_en        in   write request
//   rd_en        in   read request
//   flush        in   discard all contents
//   clr_err      in   clear sticky error flags
//   data_in      in   write data
//   data_out     out  read data
//   empty        out  count == 0
//   full         out  count == FIFO_DEPTH
//   almost_empty out  count <= AE_THRESH
//   almost_full  out  count >= AF_THRESH
//   count        out  current occupancy
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cs,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic                          flush,
    input  logic                          clr_err,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

`ifdef SYNC_FIFO_FWFT_EN
    localparam bit REG_READ = 1'b0;
`else
    localparam bit REG_READ = 1'b1;
`endif

    // Elaboration-time parameter legality checks.
    generate
        if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
            $error("sync_fifo_flex: FIFO_DEPTH must be a power of two >= 2");
        end
        if (!af_thresh_ok(AF_THRESH, FIFO_DEPTH)) begin : g_bad_af
            $error("sync_fifo_flex: AF_THRESH must be in 1..FIFO_DEPTH");
        end
        if (!ae_thresh_ok(AE_THRESH, FIFO_DEPTH)) begin : g_bad_ae
            $error("sync_fifo_flex: AE_THRESH must be in 0..FIFO_DEPTH-1");
        end
    endgenerate

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_overflow;
    logic          r_underflow;

    logic [PW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_flush;
    logic          w_clr_err;
    logic          w_wr_req;
    logic          w_rd_req;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_wr_rej;
    logic          w_rd_rej;

    // Occupancy follows from modular pointer difference; the wrap bit makes
    // full (difference == depth) distinct from empty (difference == 0).
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == DEPTH_C);

    // Flush outranks normal traffic, so requests are masked in a flush cycle;
    // this also keeps the error flags untouched by a flush.
    assign w_flush   = cs & flush;
    assign w_clr_err = cs & clr_err;
    assign w_wr_req  = cs & wr_en & ~w_flush;
    assign w_rd_req  = cs & rd_en & ~w_flush;

    // Acceptance uses the pre-edge flags: a write alongside a read while full
    // is still rejected, a read alongside a write while empty likewise.
    assign w_wr_acc = w_wr_req & ~w_full;
    assign w_rd_acc = w_rd_req & ~w_empty;
    assign w_wr_rej = w_wr_req & w_full;
    assign w_rd_rej = w_rd_req & w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // A new error in the same cycle as clr_err wins, so the set term is
    // tested before the clear term.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!w_flush) begin
            if (w_wr_rej) begin
                r_overflow <= 1'b1;
            end else if (w_clr_err) begin
                r_overflow <= 1'b0;
            end

            if (w_rd_rej) begin
                r_underflow <= 1'b1;
            end else if (w_clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW),
        .REG_READ   (REG_READ)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (data_in),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (data_out)
    );

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (w_count <= AE_C);
    assign almost_full  = (w_count >= AF_C);
    assign count        = w_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : sync_fifo_flex

// File: tb/tb_sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flex
// Directed self-checking bench for sync_fifo_flex in its default build
// (registered read, FIFO_DEPTH=8, DATA_WIDTH=32, AF_THRESH=6, AE_THRESH=2).
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sync_fifo_flex;

    localparam int DEPTH = 8;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          wr_en;
    logic          rd_en;
    logic          flush;
    logic          clr_err;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    sync_fifo_flex #(
        .FIFO_DEPTH (DEPTH),
        .DATA_WIDTH (DW),
        .AF_THRESH  (6),
        .AE_THRESH  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .flush        (flush),
        .clr_err      (clr_err),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected flags for a given occupancy with AF_THRESH=6, AE_THRESH=2.
    task automatic check_level(input string tag, input int exp_cnt);
        check({tag, ".count"}, 32'(count), 32'(exp_cnt));
        check({tag, ".empty"}, 32'(empty), 32'(exp_cnt == 0));
        check({tag, ".full"},  32'(full),  32'(exp_cnt == DEPTH));
        check({tag, ".ae"},    32'(almost_empty), 32'(exp_cnt <= 2));
        check({tag, ".af"},    32'(almost_full),  32'(exp_cnt >= 6));
    endtask

    task automatic set_in(input logic c, input logic w, input logic r,
                          input logic f, input logic ce, input logic [DW-1:0] d);
        cs      = c;
        wr_en   = w;
        rd_en   = r;
        flush   = f;
        clr_err = ce;
        data_in = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, '0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_level("reset", 0);
        check("reset.ovf",  32'(overflow),  32'd0);
        check("reset.unf",  32'(underflow), 32'd0);
        check("reset.dout", data_out,       32'd0);

        // Requests without chip select are ignored
        set_in(0, 1, 1, 0, 0, 32'hBAD);
        tick();
        check_level("nocs", 0);
        check("nocs.unf", 32'(underflow), 32'd0);

        // Fill with 0..7
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 1, 0, 0, 0, 32'(i));
            tick();
            check_level($sformatf("fill%0d", i), i + 1);
        end

        // 9th write rejected
        set_in(1, 1, 0, 0, 0, 32'hDEAD);
        tick();
        check_level("ovw", 8);
        check("ovw.ovf", 32'(overflow), 32'd1);

        // Read all 8 back: registered data appears right after each read edge
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 0, 1, 0, 0, '0);
            tick();
            check($sformatf("rd%0d.dout", i), data_out, 32'(i));
            check_level($sformatf("rd%0d", i), DEPTH - 1 - i);
        end

        // Extra read: underflow, data_out holds
        set_in(1, 0, 1, 0, 0, '0);
        tick();
        check("unr.unf",  32'(underflow), 32'd1);
        check("unr.dout", data_out,       32'd7);
        check("unr.ovf",  32'(overflow),  32'd1);
        check_level("unr", 0);

        // Clear errors
        set_in(1, 0, 0, 0, 1, '0);
        tick();
        check("clr.ovf", 32'(overflow),  32'd0);
        check("clr.unf", 32'(underflow), 32'd0);

        // Wrap-around: prime 3 words, then 20 simultaneous write+read
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 0, 0, 32'h100 + 32'(i));
            tick();
        end
        check_level("prime", 3);
        for (int i = 0; i < 20; i++) begin
            set_in(1, 1, 1, 0, 0, 32'h103 + 32'(i));
            tick();
            check($sformatf("wrap%0d.dout", i), data_out, 32'h100 + 32'(i));
            check($sformatf("wrap%0d.cnt", i),  32'(count), 32'd3);
        end
        // Remaining: 0x114, 0x115, 0x116

        // Simultaneous at count=4
        set_in(1, 1, 0, 0, 0, 32'h117);
        tick();
        check_level("c4", 4);
        set_in(1, 1, 1, 0, 0, 32'h118);
        tick();
        check_level("c4rw", 4);
        check("c4rw.dout", data_out, 32'h114);

        // Drain 0x115..0x118
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 1, 0, 0, '0);
            tick();
            check($sformatf("drain%0d.dout", i), data_out, 32'h115 + 32'(i));
        end
        check_level("drained", 0);
        check("drained.unf", 32'(underflow), 32'd0);

        // Simultaneous at empty: write accepted, read rejected
        set_in(1, 1, 1, 0, 0, 32'h200);
        tick();
        check_level("emrw", 1);
        check("emrw.unf",  32'(underflow), 32'd1);
        check("emrw.dout", data_out,       32'h118);

        // Fill to full with 0x201..0x207
        for (int i = 1; i < DEPTH; i++) begin
            set_in(1, 1, 0, 0, 0, 32'h200 + 32'(i));
            tick();
        end
        check_level("full2", 8);

        // Simultaneous at full: write rejected, read accepted
        set_in(1, 1, 1, 0, 0, 32'h300);
        tick();
        check_level("fullrw", 7);
        check("fullrw.ovf",  32'(overflow), 32'd1);
        check("fullrw.dout", data_out,      32'h200);

        // Down to count 5
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 1, 0, 0, '0);
            tick();
        end
        check_level("c5", 5);
        check("c5.dout", data_out, 32'h202);

        // Flush with a concurrent write: everything dropped, flags/data held
        set_in(1, 1, 0, 1, 0, 32'h400);
        tick();
        check_level("flush", 0);
        check("flush.dout", data_out,       32'h202);
        check("flush.ovf",  32'(overflow),  32'd1);
        check("flush.unf",  32'(underflow), 32'd1);

        // The flushed-cycle word must not appear
        set_in(1, 1, 0, 0, 0, 32'h500);
        tick();
        check_level("pf_wr", 1);
        set_in(1, 0, 1, 0, 0, '0);
        tick();
        check("pf_rd.dout", data_out, 32'h500);
        check_level("pf_rd", 0);

        // Fill, then clr_err in the same cycle as a new overflow
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 1, 0, 0, 0, 32'h600 + 32'(i));
            tick();
        end
        check_level("full3", 8);
        set_in(1, 1, 0, 0, 1, 32'h6FF);
        tick();
        check("clrov.ovf", 32'(overflow),  32'd1);
        check("clrov.unf", 32'(underflow), 32'd0);
        check_level("clrov", 8);

        // Down to count 6, then reset with everything active
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 1, 0, 0, '0);
            tick();
        end
        check_level("c6", 6);
        check("c6.dout", data_out, 32'h601);
        rst = 1'b1;
        set_in(1, 1, 1, 0, 0, 32'h777);
        tick();
        check_level("rstmid", 0);
        check("rstmid.ovf",  32'(overflow),  32'd0);
        check("rstmid.unf",  32'(underflow), 32'd0);
        check("rstmid.dout", data_out,       32'd0);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, '0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo_flex
